// File: rtl/if_id_register_pkg.sv
// Shared constants and FSM state type for the IF/ID pipeline register.
package if_id_register_pkg;

  localparam int          IFID_DATA_W      = 16;
  localparam logic [15:0] IFID_NOP_WORD    = 16'h0000;
  localparam logic [3:0]  IFID_HALT_OPCODE = 4'hF;
  localparam int          IFID_CNT_W       = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifid_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register for the 16-bit core with a unified instruction/data memory.
// Drops fetch slots stolen by MEM data accesses and freezes fetch for good after a HALT.
module if_id_register
  import if_id_register_pkg::*;
#(
  parameter int                DATA_W      = IFID_DATA_W,
  parameter logic [DATA_W-1:0] NOP_WORD    = IFID_NOP_WORD,
  parameter logic [3:0]        HALT_OPCODE = IFID_HALT_OPCODE,
  parameter int                CNT_W       = IFID_CNT_W
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_plus2_in,
  input  logic              mem_busy,
  input  logic              stall_hd,
  input  logic              flush,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pc_plus2_out,
  output logic              valid_out,
  output logic              pc_freeze_sh,
  output logic              power_freeze_pc_sh,
  output logic [CNT_W-1:0]  bubble_count
);

  ifid_state_t       r_state, w_next_state;
  logic [DATA_W-1:0] r_instr, r_pc;
  logic              r_vld, r_pfz;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_capture, w_bubble;

  // When memory serves a data access the word on instr_in is not ours: fetch must retry.
  assign pc_freeze_sh = mem_busy;

  always_comb begin
    w_capture    = 1'b0;
    w_bubble     = 1'b0;
    w_next_state = r_state;
    if (!flush && !stall_hd) begin
      if (mem_busy || (r_state == HALT)) w_bubble  = 1'b1;
      else                               w_capture = 1'b1;
    end
    // Opcode only matters on a real capture; data words never halt.
    if (w_capture && (instr_in[DATA_W-1 -: 4] == HALT_OPCODE)) w_next_state = HALT;
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      r_state <= RUN;
      r_pfz   <= 1'b0;
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pfz   <= (r_state == HALT);
      if (flush || w_bubble) begin
        r_instr <= NOP_WORD;
        r_vld   <= 1'b0;
      end else if (w_capture) begin
        r_instr <= instr_in;
        r_pc    <= pc_plus2_in;
        r_vld   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest)                         r_cnt <= '0;
    else if (w_bubble && ~&r_cnt)     r_cnt <= r_cnt + 1'b1;
  end

  assign instr_out          = r_instr;
  assign pc_plus2_out       = r_pc;
  assign valid_out          = r_vld;
  assign power_freeze_pc_sh = r_pfz;
  assign bubble_count       = r_cnt;

endmodule

// File: tb/tb_if_id_register.sv
// Scoreboard bench for if_id_register: driver pushes predicted outputs, negedge monitor compares.
module tb_if_id_register;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rest;
  logic [15:0] instr_in, pc_plus2_in;
  logic        mem_busy, stall_hd, flush;
  logic [15:0] instr_out, pc_plus2_out;
  logic        valid_out, pc_freeze_sh, power_freeze_pc_sh;
  logic [CW-1:0] bubble_count;

  if_id_register #(.CNT_W(CW)) dut (
    .clk(clk), .rest(rest), .instr_in(instr_in), .pc_plus2_in(pc_plus2_in),
    .mem_busy(mem_busy), .stall_hd(stall_hd), .flush(flush),
    .instr_out(instr_out), .pc_plus2_out(pc_plus2_out), .valid_out(valid_out),
    .pc_freeze_sh(pc_freeze_sh), .power_freeze_pc_sh(power_freeze_pc_sh),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        vld;
    logic        pfz;
    logic        pcf;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // reference state: what decode should currently see
  logic [15:0] m_instr, m_pc;
  logic        m_vld, m_pfz;
  bit          m_halted;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("instr_out",    {16'h0, instr_out},    {16'h0, e.instr});
      chk("pc_plus2_out", {16'h0, pc_plus2_out}, {16'h0, e.pc});
      chk("valid_out",    {31'h0, valid_out},    {31'h0, e.vld});
      chk("power_freeze", {31'h0, power_freeze_pc_sh}, {31'h0, e.pfz});
      chk("pc_freeze",    {31'h0, pc_freeze_sh}, {31'h0, e.pcf});
      chk("bubble_count", {28'h0, bubble_count}, {28'h0, e.cnt});
    end
  end

  task automatic model_reset();
    m_instr = 16'h0000; m_pc = 16'h0000; m_vld = 1'b0;
    m_pfz = 1'b0; m_halted = 1'b0; m_cnt = 0;
  endtask

  // Apply inputs for one cycle, predict, and advance past the next rising edge.
  task automatic step(input logic f, input logic s, input logic m,
                      input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    flush = f; stall_hd = s; mem_busy = m; instr_in = ins; pc_plus2_in = pc;
    e.instr = m_instr; e.pc = m_pc; e.vld = m_vld; e.pfz = m_pfz;
    e.pcf = m; e.cnt = 4'(m_cnt);
    q.push_back(e);
    // the halt freeze reports whether we were already halted a cycle earlier
    m_pfz = m_halted;
    if (f) begin
      m_instr = 16'h0000; m_vld = 1'b0;
    end else if (!s) begin
      if (m || m_halted) begin
        m_instr = 16'h0000; m_vld = 1'b0;
        m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      end else begin
        m_instr = ins; m_pc = pc; m_vld = 1'b1;
        if (ins[15:12] == 4'hF) m_halted = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted between edges must clear outputs with no clock.
  task automatic do_reset();
    #6;
    rest = 1'b1;
    #1;
    chk("rst_instr", {16'h0, instr_out},    32'h0);
    chk("rst_pc",    {16'h0, pc_plus2_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out},    32'h0);
    chk("rst_pfz",   {31'h0, power_freeze_pc_sh}, 32'h0);
    chk("rst_cnt",   {28'h0, bubble_count}, 32'h0);
    @(posedge clk); #1;
    rest = 1'b0;
    model_reset();
  endtask

  initial begin
    rest = 1'b1; flush = 0; stall_hd = 0; mem_busy = 0;
    instr_in = 16'h0; pc_plus2_in = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rest = 1'b0;

    do_reset();
    step(0, 0, 0, 16'h1234, 16'h0002);
    step(0, 0, 1, 16'hF000, 16'h0004);
    step(0, 0, 0, 16'h1234, 16'h0006);
    chk("cap_direct", {16'h0, instr_out}, 32'h1234);
    repeat (3) step(0, 1, 1, 16'($urandom), 16'($urandom));
    step(0, 0, 0, 16'h4321, 16'h0008);
    step(1, 1, 0, 16'h5555, 16'h000A);
    step(0, 0, 0, 16'hF001, 16'h000C);
    repeat (4) step(0, 0, 0, 16'h2222, 16'h000E);
    step(1, 0, 0, 16'h3333, 16'h0010);
    step(0, 0, 0, 16'h4444, 16'h0012);
    chk("halt_direct", {31'h0, power_freeze_pc_sh}, 32'h1);

    do_reset();
    step(1, 0, 0, 16'hF00F, 16'h0020);
    step(0, 0, 0, 16'h1111, 16'h0022);
    repeat (20) step(0, 0, 1, 16'hF0F0, 16'h0024);
    step(0, 1, 0, 16'h0000, 16'h0026);
    chk("sat_direct", {28'h0, bubble_count}, 32'hF);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 49) do_reset();
      else step(($urandom % 8) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
                16'($urandom), 16'($urandom));
    end
    step(0, 1, 0, 16'h0, 16'h0);
    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Pipeline register between the 16-bit fetch stage and decode.
- Captures the fetched instruction word and PC+2 from the unified instruction/data memory.
- Drops fetch slots that were stolen by MEM-stage data accesses, and holds its contents on decode hazards.
- Owns the structural-hazard freeze outputs back to fetch: the per-access PC freeze, and the sticky HALT power freeze.

Parameters:
- DATA_W, 16, width of instruction word and PC.
- NOP_WORD, 16'h0000, instruction value driven while the slot is a bubble.
- HALT_OPCODE, 4'hF, opcode in instr_in[15:12] that halts fetch.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- rest  in  1  reset, asynchronous, active-high.
- instr_in  in  DATA_W  word returned by the unified memory this cycle.
- pc_plus2_in  in  DATA_W  PC+2 from the fetch adder.
- mem_busy  in  1  MemRead OR MemWrite from the MEM stage. When high, instr_in is data, not an instruction.
- stall_hd  in  1  decode hazard stall: hold the register.
- flush  in  1  brTaken OR Jump: discard the slot.
- instr_out  out  DATA_W  instruction to decode.
- pc_plus2_out  out  DATA_W  PC+2 to decode.
- valid_out  out  1  instr_out is a real instruction.
- pc_freeze_sh  out  1  structural freeze to fetch (PCFreze_SH).
- power_freeze_pc_sh  out  1  sticky halt freeze to fetch (PowerFrezePC_SH).
- bubble_count  out  CNT_W  count of bubbles inserted, saturating.

Behaviour:
- Reset (async, rest=1): instr_out=NOP_WORD, pc_plus2_out=0, valid_out=0, bubble_count=0, FSM=RUN, power_freeze_pc_sh=0.
- pc_freeze_sh is combinational and equals mem_busy. The fetch slot is lost, so the PC must re-fetch the same address.
- Register update on each rising edge, strict priority:
  1. flush=1: instr_out<=NOP_WORD, valid_out<=0, pc_plus2_out unchanged. No bubble count. Overrides stall_hd and mem_busy.
  2. stall_hd=1: all register outputs hold. This also holds when mem_busy=1 in the same cycle.
  3. mem_busy=1: instr_out<=NOP_WORD, valid_out<=0. bubble_count increments and saturates at all-ones.
  4. FSM=HALT: same as case 3. The bubble is counted.
  5. Otherwise (capture): instr_out<=instr_in, pc_plus2_out<=pc_plus2_in, valid_out<=1.
- Latency: one cycle from instr_in to instr_out.
- FSM states are RUN and HALT.
  - RUN->HALT on a cycle where case 5 captures a word with instr_in[15:12]==HALT_OPCODE.
  - The HALT word itself is passed to decode with valid_out=1.
  - power_freeze_pc_sh is a registered output: it is 1 starting the cycle after entry to HALT.
  - HALT->RUN only via rest.
  - A flush while in HALT does not leave HALT.
  - A flush in the same cycle as a HALT word arrives means no capture, so no transition to HALT.
- The HALT opcode is only examined on a capture. A data word equal to the HALT opcode during mem_busy must not halt.
- Reset asserted mid-operation clears everything immediately. No clock edge is required.

Decomposition:
- Shared package holds NOP_WORD, HALT_OPCODE, DATA_W, and the FSM state enum {RUN, HALT}.
- No sub-module needed. The saturating counter may be a small local always block.

Test Plan:
- Reset then capture: rest pulse, then instr_in=16'h1234, pc_plus2_in=16'h0002 -> next edge gives instr_out=16'h1234, pc_plus2_out=16'h0002, valid_out=1, power_freeze_pc_sh=0.
- Stolen slot: mem_busy=1 with instr_in=16'hF000 -> pc_freeze_sh=1 in the same cycle; next edge gives instr_out=16'h0000, valid_out=0, bubble_count=1, no HALT.
- Stall vs mem_busy: register holds 16'h1234; assert stall_hd=1 and mem_busy=1 for 3 cycles -> outputs unchanged, bubble_count unchanged.
- Flush priority: flush=1, stall_hd=1, instr_in=16'h5555 -> instr_out=16'h0000, valid_out=0.
- Halt: capture 16'hF001 -> valid_out=1 with 16'hF001; power_freeze_pc_sh=1 from the following cycle; later inputs yield bubbles and bubble_count increments; rest returns to RUN.
- Saturation and async reset: CNT_W=4, 20 mem_busy cycles -> bubble_count=4'hF; assert rest between edges -> all outputs reset immediately.
